// File: rtl/lsu_if.sv
// Word-wide data-memory port between the load/store unit (master) and the
// data memory (slave).
interface lsu_if #(
    parameter int ADDR_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit: turns byte/half/word accesses into byte-enabled word
// transactions, splitting accesses that straddle a word boundary in two.
module lsu #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic [31:0]       load_data,
    output logic              done,
    output logic              fault,
    output logic              stall,
    lsu_if.master             mem
);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

    state_t state, state_nxt;

    logic              cmd_load;
    logic              cmd_fault;
    logic [2:0]        cmd_f3;
    logic [ADDR_W-3:0] cmd_word;
    logic [1:0]        cmd_off;
    logic [31:0]       cmd_data;
    logic [31:0]       hold;

    logic              illegal;
    logic [3:0]        base;
    logic [7:0]        mask;
    logic              split;
    logic [63:0]       wide_wdata;
    logic [31:0]       rdata_al;
    logic [31:0]       ext_rdata;
    logic [ADDR_W-3:0] next_word;
    logic              last_ack;

    assign illegal = (is_load == is_store)
                   || (is_load  && (funct3 == 3'b011 || funct3[2:1] == 2'b11))
                   || (is_store && !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010));

    always_comb begin
        case (cmd_f3[1:0])
            2'b00:   base = 4'b0001;
            2'b01:   base = 4'b0011;
            default: base = 4'b1111;
        endcase
    end

    // Upper mask/data halves belong to the second word of a split access.
    assign mask       = {4'b0000, base} << cmd_off;
    assign split      = |mask[7:4];
    assign wide_wdata = {32'b0, cmd_data} << {cmd_off, 3'b000};
    assign next_word  = cmd_word + (ADDR_W-2)'(1);

    assign rdata_al = 32'((state == ACC2 ? {mem.mem_rdata, hold} : {32'b0, mem.mem_rdata})
                          >> {cmd_off, 3'b000});

    always_comb begin
        case (cmd_f3)
            3'b000:  ext_rdata = {{24{rdata_al[7]}}, rdata_al[7:0]};
            3'b001:  ext_rdata = {{16{rdata_al[15]}}, rdata_al[15:0]};
            3'b100:  ext_rdata = {24'b0, rdata_al[7:0]};
            3'b101:  ext_rdata = {16'b0, rdata_al[15:0]};
            default: ext_rdata = rdata_al;
        endcase
    end

    assign last_ack = mem.mem_ack && ((state == ACC1 && !split) || state == ACC2);

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = illegal ? RESP : ACC1;
            ACC1:    if (mem.mem_ack) state_nxt = split ? ACC2 : RESP;
            ACC2:    if (mem.mem_ack) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        mem.mem_be    = '0;
        done          = 1'b0;
        fault         = 1'b0;
        stall         = 1'b0;
        case (state)
            IDLE: stall = req_valid;
            ACC1: begin
                stall         = 1'b1;
                mem.mem_req   = 1'b1;
                mem.mem_we    = !cmd_load;
                mem.mem_addr  = {cmd_word, 2'b00};
                mem.mem_be    = mask[3:0];
                mem.mem_wdata = wide_wdata[31:0];
            end
            ACC2: begin
                stall         = 1'b1;
                mem.mem_req   = 1'b1;
                mem.mem_we    = !cmd_load;
                mem.mem_addr  = {next_word, 2'b00};
                mem.mem_be    = mask[7:4];
                mem.mem_wdata = wide_wdata[63:32];
            end
            RESP: begin
                done  = 1'b1;
                fault = cmd_fault;
            end
            default: ;
        endcase
    end

    // NOTE: datapath registers are reset as well, so load_data and hold read 0 straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_load  <= 1'b0;
            cmd_fault <= 1'b0;
            cmd_f3    <= '0;
            cmd_word  <= '0;
            cmd_off   <= '0;
            cmd_data  <= '0;
            hold      <= '0;
            load_data <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                cmd_load  <= is_load;
                cmd_fault <= illegal;
                cmd_f3    <= funct3;
                cmd_word  <= addr[ADDR_W-1:2];
                cmd_off   <= addr[1:0];
                cmd_data  <= store_data;
            end
            if (state == ACC1 && mem.mem_ack) hold <= mem.mem_rdata;
            if (last_ack && cmd_load) load_data <= ext_rdata;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Randomised and directed checks of the load/store unit against a byte-level
// memory model and a reference computed from the RV32I access rules.
module tb_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [7:0]  addr;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        done;
    logic        fault;
    logic        stall;

    lsu_if #(.ADDR_W(8)) bus ();

    lsu #(.ADDR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .is_load    (is_load),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .load_data  (load_data),
        .done       (done),
        .fault      (fault),
        .stall      (stall),
        .mem        (bus)
    );

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

    int          vectors = 0;
    int          errors  = 0;
    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];
    txn_t        log_q[$];
    int          mem_wait = 0;
    bit          spurious_en = 1'b0;
    int          bus_errs = 0;
    int          acc_cnt = 0;
    int          seen_acc = 0;
    int          wait_cnt = 0;
    bit          in_txn = 1'b0;
    txn_t        snap;
    logic [7:0]  ra;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: programmable wait states, optional acks while idle,
    // and a watch on bus stability and idle-zero outputs.
    always @(negedge clk) begin
        if (acc_cnt != seen_acc) begin
            seen_acc = acc_cnt;
            in_txn   = 1'b0;
            wait_cnt = 0;
        end
        if (bus.mem_req === 1'b1) begin
            if (!in_txn) begin
                snap   = '{bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata};
                in_txn = 1'b1;
            end else if ({bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata} !== snap) begin
                bus_errs++;
            end
            if (bus.mem_addr[1:0] !== 2'b00) bus_errs++;
            bus.mem_ack = (wait_cnt >= mem_wait);
            if (wait_cnt < mem_wait) wait_cnt++;
            ra = bus.mem_addr;
            bus.mem_rdata = {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};
        end else begin
            in_txn   = 1'b0;
            wait_cnt = 0;
            if ({bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata} !== '0) bus_errs++;
            bus.mem_ack   = spurious_en ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.mem_rdata = $urandom;
        end
    end

    always @(posedge clk) begin
        if (bus.mem_req === 1'b1 && bus.mem_ack === 1'b1) begin
            log_q.push_back('{bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata});
            if (bus.mem_we)
                for (int i = 0; i < 4; i++)
                    if (bus.mem_be[i]) mem[bus.mem_addr + 8'(i)] = bus.mem_wdata[8*i +: 8];
            acc_cnt++;
        end
    end

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [7:0] a);
        logic [31:0] v = '0;
        for (int i = 0; i < size_of(f3); i++) v[8*i +: 8] = ref_mem[8'(a + 8'(i))];
        case (f3)
            3'b000:  return 32'($signed(v[7:0]));
            3'b001:  return 32'($signed(v[15:0]));
            default: return v;
        endcase
    endfunction

    // Starts in the cycle after the previous done, so consecutive calls are back-to-back.
    task automatic do_op(input bit ld, input bit st, input logic [2:0] f3, input logic [7:0] a,
                         input logic [31:0] sd, output int lat, output logic [31:0] ldv,
                         output logic flt, output logic st0);
        @(posedge clk); #1;
        log_q.delete();
        req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
        #1 st0 = stall;
        lat = 0;
        while (lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (done === 1'b1) break;
        end
        ldv = load_data;
        flt = fault;
        req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
        funct3 = '0; addr = '0; store_data = '0;
        #3;
        vectors++; if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata} !== '0) begin errors++; $display("FAIL reset_bus: got %h want 0", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata}); end
        vectors++; if ({done, fault} !== 2'b00) begin errors++; $display("FAIL reset_done_fault: got %b want 00", {done, fault}); end
        vectors++; if (load_data !== 32'h0) begin errors++; $display("FAIL reset_load_data: got %h want 0", load_data); end
        req_valid = 1'b1; #1;
        vectors++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall_hi: got %b want 1", stall); end
        req_valid = 1'b0; #1;
        vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall_lo: got %b want 0", stall); end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_lw();
        int lat; logic [31:0] ldv; logic flt, st0;
        mem[8] = 8'h38; mem[9] = 8'h00; mem[10] = 8'h00; mem[11] = 8'h00;
        mem_wait = 0;
        do_op(1'b1, 1'b0, 3'b010, 8'h08, 32'h0, lat, ldv, flt, st0);
        vectors++; if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d want 2", lat); end
        vectors++; if (ldv !== 32'h38) begin errors++; $display("FAIL lw_data: got %h want 00000038", ldv); end
        vectors++; if (st0 !== 1'b1 || flt !== 1'b0) begin errors++; $display("FAIL lw_stall_fault: got %b%b want 10", st0, flt); end
        vectors++; if (log_q.size() !== 1 || log_q[0] !== txn_t'({1'b0, 8'h08, 4'b1111, 32'h0})) begin errors++; $display("FAIL lw_txn: got %0d txns first %h want 1 txn be 1111 @08", log_q.size(), log_q.size() > 0 ? log_q[0] : '0); end
    endtask

    task automatic test_lh_split();
        int lat; logic [31:0] ldv; logic flt, st0;
        txn_t exp_t [2];
        mem[3] = 8'h80; mem[4] = 8'hFF;
        exp_t[0] = '{1'b0, 8'h00, 4'b1000, 32'h0};
        exp_t[1] = '{1'b0, 8'h04, 4'b0001, 32'h0};
        do_op(1'b1, 1'b0, 3'b001, 8'h03, 32'h0, lat, ldv, flt, st0);
        vectors++; if (lat !== 3) begin errors++; $display("FAIL lh_latency: got %0d want 3", lat); end
        vectors++; if (ldv !== 32'hFFFF_FF80) begin errors++; $display("FAIL lh_data: got %h want ffffff80", ldv); end
        vectors++; if (log_q.size() !== 2) begin errors++; $display("FAIL lh_txn_count: got %0d want 2", log_q.size()); end
        for (int i = 0; i < 2; i++) begin
            vectors++; if (i >= log_q.size() || log_q[i] !== exp_t[i]) begin errors++; $display("FAIL lh_txn%0d: got %h want %h", i, i < log_q.size() ? log_q[i] : '0, exp_t[i]); end
        end
    endtask

    task automatic test_sw_split();
        int lat; logic [31:0] ldv; logic flt, st0;
        txn_t exp_t [2];
        exp_t[0] = '{1'b1, 8'h00, 4'b1100, 32'hCCDD_0000};
        exp_t[1] = '{1'b1, 8'h04, 4'b0011, 32'h0000_AABB};
        do_op(1'b0, 1'b1, 3'b010, 8'h02, 32'hAABB_CCDD, lat, ldv, flt, st0);
        vectors++; if (lat !== 3) begin errors++; $display("FAIL sw_latency: got %0d want 3", lat); end
        for (int i = 0; i < 2; i++) begin
            vectors++; if (i >= log_q.size() || log_q[i] !== exp_t[i]) begin errors++; $display("FAIL sw_txn%0d: got %h want %h", i, i < log_q.size() ? log_q[i] : '0, exp_t[i]); end
        end
        vectors++; if ({mem[5], mem[4], mem[3], mem[2]} !== 32'hAABB_CCDD) begin errors++; $display("FAIL sw_memory: got %h want aabbccdd", {mem[5], mem[4], mem[3], mem[2]}); end
        vectors++; if (ldv !== 32'hFFFF_FF80) begin errors++; $display("FAIL sw_keeps_load_data: got %h want ffffff80", ldv); end
    endtask

    task automatic test_byte_wait();
        int lat; logic [31:0] ldv; logic flt, st0;
        mem[5] = 8'h9C;
        mem_wait = 0;
        do_op(1'b1, 1'b0, 3'b100, 8'h05, 32'h0, lat, ldv, flt, st0);
        vectors++; if (lat !== 2) begin errors++; $display("FAIL lbu_latency: got %0d want 2", lat); end
        vectors++; if (ldv !== 32'h0000_009C) begin errors++; $display("FAIL lbu_data: got %h want 0000009c", ldv); end
        mem_wait = 3;
        do_op(1'b1, 1'b0, 3'b000, 8'h05, 32'h0, lat, ldv, flt, st0);
        mem_wait = 0;
        vectors++; if (lat !== 5) begin errors++; $display("FAIL lb_wait_latency: got %0d want 5", lat); end
        vectors++; if (ldv !== 32'hFFFF_FF9C) begin errors++; $display("FAIL lb_data: got %h want ffffff9c", ldv); end
        vectors++; if (log_q.size() !== 1 || log_q[0] !== txn_t'({1'b0, 8'h04, 4'b0010, 32'h0})) begin errors++; $display("FAIL lb_txn: got %0d txns first %h want be 0010 @04", log_q.size(), log_q.size() > 0 ? log_q[0] : '0); end
        vectors++; if (bus_errs !== 0) begin errors++; $display("FAIL wait_bus_stable: got %0d bus violations want 0", bus_errs); end
    endtask

    task automatic test_wrap();
        int lat; logic [31:0] ldv; logic flt, st0;
        txn_t exp_t [2];
        mem[8'hFE] = 8'h33; mem[8'hFF] = 8'h00; mem[8'h00] = 8'h00; mem[8'h01] = 8'h5A;
        exp_t[0] = '{1'b1, 8'hFC, 4'b1000, 32'hEF00_0000};
        exp_t[1] = '{1'b1, 8'h00, 4'b0001, 32'h0012_34BE};
        do_op(1'b0, 1'b1, 3'b001, 8'hFF, 32'h1234_BEEF, lat, ldv, flt, st0);
        vectors++; if (lat !== 3) begin errors++; $display("FAIL wrap_latency: got %0d want 3", lat); end
        for (int i = 0; i < 2; i++) begin
            vectors++; if (i >= log_q.size() || log_q[i] !== exp_t[i]) begin errors++; $display("FAIL wrap_txn%0d: got %h want %h", i, i < log_q.size() ? log_q[i] : '0, exp_t[i]); end
        end
        vectors++; if ({mem[8'h01], mem[8'h00], mem[8'hFF], mem[8'hFE]} !== 32'h5ABE_EF33) begin errors++; $display("FAIL wrap_memory: got %h want 5abeef33", {mem[8'h01], mem[8'h00], mem[8'hFF], mem[8'hFE]}); end
    endtask

    task automatic test_fault();
        int lat; logic [31:0] ldv; logic flt, st0;
        logic [4:0] cases [4];
        cases[0] = {1'b1, 1'b0, 3'b011};
        cases[1] = {1'b1, 1'b1, 3'b010};
        cases[2] = {1'b0, 1'b1, 3'b100};
        cases[3] = {1'b0, 1'b0, 3'b000};
        mem[8] = 8'h38; mem[9] = 8'h00; mem[10] = 8'h00; mem[11] = 8'h00;
        do_op(1'b1, 1'b0, 3'b010, 8'h08, 32'h0, lat, ldv, flt, st0);
        for (int i = 0; i < 4; i++) begin
            do_op(cases[i][4], cases[i][3], cases[i][2:0], 8'h08, 32'hDEAD_BEEF, lat, ldv, flt, st0);
            vectors++; if (lat !== 1 || flt !== 1'b1) begin errors++; $display("FAIL fault%0d_timing: got lat %0d fault %b want lat 1 fault 1", i, lat, flt); end
            vectors++; if (log_q.size() !== 0 || ldv !== 32'h38) begin errors++; $display("FAIL fault%0d_effect: got %0d txns load_data %h want 0 txns 00000038", i, log_q.size(), ldv); end
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] ldv; logic flt, st0;
        mem_wait = 1;
        do_op(1'b1, 1'b0, 3'b010, 8'h08, 32'h0, lat, ldv, flt, st0);
        vectors++; if (lat !== 3 || ldv !== 32'h38) begin errors++; $display("FAIL b2b_lw: got lat %0d data %h want lat 3 data 00000038", lat, ldv); end
        do_op(1'b0, 1'b1, 3'b010, 8'h10, 32'hA1B2_C3D4, lat, ldv, flt, st0);
        vectors++; if (lat !== 3 || st0 !== 1'b1) begin errors++; $display("FAIL b2b_sw: got lat %0d stall %b want lat 3 stall 1", lat, st0); end
        do_op(1'b1, 1'b0, 3'b100, 8'h12, 32'h0, lat, ldv, flt, st0);
        vectors++; if (lat !== 3 || ldv !== 32'h0000_00B2) begin errors++; $display("FAIL b2b_lbu: got lat %0d data %h want lat 3 data 000000b2", lat, ldv); end
        mem_wait = 0;
    endtask

    task automatic test_random();
        int lat, w, n, exp_lat, sz, bad;
        logic [31:0] ldv, ref_ld, sd;
        logic flt, st0;
        bit ld, st, ill;
        logic [2:0] f3;
        logic [7:0] a, b;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            mem[i] = b;
            ref_mem[i] = b;
        end
        ref_ld = 'x;
        for (int k = 0; k < 200; k++) begin
            case ($urandom_range(0, 9))
                0:             begin ld = 1'($urandom_range(0, 1)); st = ld; end
                1, 2, 3, 4, 5: begin ld = 1'b1; st = 1'b0; end
                default:       begin ld = 1'b0; st = 1'b1; end
            endcase
            f3 = 3'($urandom_range(0, 7));
            if (k == 0) begin ld = 1'b1; st = 1'b0; f3 = 3'b010; end
            a  = 8'($urandom_range(0, 255));
            sd = $urandom;
            w  = $urandom_range(0, 2);
            mem_wait    = w;
            spurious_en = 1'($urandom_range(0, 1));
            ill = (ld == st) || (ld && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) || (st && f3 > 3'd2);
            sz  = size_of(f3);
            n   = (int'(a % 4) + sz > 4) ? 2 : 1;
            exp_lat = ill ? 1 : 1 + n * (w + 1);
            if (!ill && ld) ref_ld = ref_load(f3, a);
            if (!ill && st) for (int i = 0; i < sz; i++) ref_mem[8'(a + 8'(i))] = sd[8*i +: 8];
            do_op(ld, st, f3, a, sd, lat, ldv, flt, st0);
            vectors++; if (lat !== exp_lat) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d (ld %b st %b f3 %b addr %h wait %0d)", k, lat, exp_lat, ld, st, f3, a, w); end
            vectors++; if (flt !== ill) begin errors++; $display("FAIL rand%0d_fault: got %b want %b", k, flt, ill); end
            vectors++; if (ldv !== ref_ld) begin errors++; $display("FAIL rand%0d_load_data: got %h want %h (f3 %b addr %h)", k, ldv, ref_ld, f3, a); end
            if ($urandom_range(0, 3) == 0) @(posedge clk);
        end
        spurious_en = 1'b0;
        mem_wait = 0;
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        vectors++; if (bad !== 0) begin errors++; $display("FAIL rand_memory: got %0d differing bytes want 0", bad); end
        vectors++; if (bus_errs !== 0) begin errors++; $display("FAIL rand_bus_protocol: got %0d bus violations want 0", bus_errs); end
    endtask

    task automatic test_reset_mid_split();
        for (int i = 0; i < 8; i++) mem[i] = 8'(8'h10 + i);
        mem_wait = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; is_load = 1'b0; is_store = 1'b1; funct3 = 3'b010;
        addr = 8'h02; store_data = 32'h5566_7788;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h04) begin errors++; $display("FAIL rstmid_in_acc2: got req %b addr %h want req 1 addr 04", bus.mem_req, bus.mem_addr); end
        rst = 1'b1; #1;
        vectors++; if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata} !== '0) begin errors++; $display("FAIL rstmid_bus: got %h want 0", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata}); end
        vectors++; if ({done, fault} !== 2'b00 || load_data !== 32'h0) begin errors++; $display("FAIL rstmid_outputs: got done/fault %b load_data %h want 00 00000000", {done, fault}, load_data); end
        vectors++; if (stall !== 1'b1) begin errors++; $display("FAIL rstmid_stall: got %b want 1", stall); end
        req_valid = 1'b0; is_store = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++; if ({mem[5], mem[4]} !== 16'h1514) begin errors++; $display("FAIL rstmid_second_word: got %h want 1514", {mem[5], mem[4]}); end
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_lw();
        test_lh_split();
        test_sw_split();
        test_byte_wait();
        test_wrap();
        test_fault();
        test_back_to_back();
        test_random();
        test_reset_mid_split();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
